// File: rtl/iic_pkg.sv
// Shared IIC definitions for the byte reader and byte writer:
// state encoding, default SCL half-period, ACK/NACK bus levels, bit counter width.
package iic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD_L   = 3'd1,
        ST_RD_H   = 3'd2,
        ST_ACK_L  = 3'd3,
        ST_ACK_H  = 3'd4,
        ST_STOP_L = 3'd5,
        ST_STOP_H = 3'd6,
        ST_DONE   = 3'd7
    } iic_state_e;

    localparam int   IIC_DELAY_DEF = 5;
    localparam logic IIC_ACK       = 1'b0;
    localparam logic IIC_NACK      = 1'b1;
    localparam int   IIC_BCNT_W    = 4;

    // SCL is high in every "_H" phase of a transfer.
    function automatic logic iic_is_high_phase(input iic_state_e st);
        logic hi;
        case (st)
            ST_RD_H, ST_ACK_H, ST_STOP_H: hi = 1'b1;
            default:                      hi = 1'b0;
        endcase
        return hi;
    endfunction

endpackage

// File: rtl/iic_sda_sync.sv
// Two-flop synchronizer for the SDA pin; resets to the idle (high) bus level.
module iic_sda_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic sda_in,
    output logic sda_sync
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    // Next values: shift the pin through two stages.
    always_comb begin
        meta_d = sda_in;
        sync_d = meta_q;
    end

    // Synchronizer flops, idle-high after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign sda_sync = sync_q;

endmodule

// File: rtl/iic_readbyte.sv
// Single-byte IIC master read engine: clocks eight bits in MSB first, drives
// ACK/NACK on the ninth clock and, when IIC_READ_STOP_EN is defined, finishes
// with a STOP condition. Without the macro the bus is left with SCL low and SDA
// released so a repeated read or an external STOP can follow.
module iic_readbyte
    import iic_pkg::*;
#(
    parameter int DELAY = IIC_DELAY_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_read,
    input  logic       ack_en,
    inout  wire        sda,
    output logic       scl,
    output logic       sda_dir,
    output logic [7:0] data,
    output logic       done,
    output logic       busy
);

    localparam int              PH_W    = $clog2(DELAY);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(DELAY - 1);
    localparam logic [PH_W-1:0] PH_MID  = PH_W'(DELAY / 2);
    localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);
    localparam logic [PH_W-1:0] PH_ZERO = PH_W'(0);

    iic_state_e            state_q, state_d;
    logic [PH_W-1:0]       ph_cnt_q, ph_cnt_d;
    logic [IIC_BCNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [7:0]            shreg_q, shreg_d;
    logic                  ack_lat_q, ack_lat_d;
    logic [7:0]            data_q, data_d;
    logic                  scl_q, scl_d;
    logic                  sda_dir_q, sda_dir_d;
    logic                  sda_out_q, sda_out_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic                  sda_sync_s;
    logic                  ph_end_s;

    iic_sda_sync u_sda_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .sda_in   (sda),
        .sda_sync (sda_sync_s)
    );

    assign ph_end_s = (ph_cnt_q == PH_LAST);

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d   = state_q;
        ph_cnt_d  = ph_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        ack_lat_d = ack_lat_q;
        data_d    = data_q;
        scl_d     = scl_q;
        sda_dir_d = sda_dir_q;
        sda_out_d = sda_out_q;

        // Phase counter runs only inside a transfer.
        if ((state_q == ST_IDLE) || (state_q == ST_DONE)) begin
            ph_cnt_d = PH_ZERO;
        end else if (ph_end_s) begin
            ph_cnt_d = PH_ZERO;
        end else begin
            ph_cnt_d = ph_cnt_q + PH_ONE;
        end

        case (state_q)
            ST_IDLE: begin
                if (en_read) begin
                    ack_lat_d = ack_en;
                    bit_cnt_d = {IIC_BCNT_W{1'b0}};
                    state_d   = ST_RD_L;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_RD_L: begin
                if (ph_end_s) begin
                    state_d = ST_RD_H;
                end else begin
                    state_d = ST_RD_L;
                end
            end
            ST_RD_H: begin
                if (ph_cnt_q == PH_MID) begin
                    shreg_d = {shreg_q[6:0], sda_sync_s};
                end else begin
                    shreg_d = shreg_q;
                end
                if (ph_end_s) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        state_d = ST_ACK_L;
                    end else begin
                        state_d = ST_RD_L;
                    end
                end else begin
                    state_d = ST_RD_H;
                end
            end
            ST_ACK_L: begin
                if (ph_end_s) begin
                    state_d = ST_ACK_H;
                end else begin
                    state_d = ST_ACK_L;
                end
            end
            ST_ACK_H: begin
                if (ph_end_s) begin
`ifdef IIC_READ_STOP_EN
                    state_d = ST_STOP_L;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    state_d = ST_ACK_H;
                end
            end
`ifdef IIC_READ_STOP_EN
            ST_STOP_L: begin
                if (ph_end_s) begin
                    state_d = ST_STOP_H;
                end else begin
                    state_d = ST_STOP_L;
                end
            end
            ST_STOP_H: begin
                if (ph_end_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_STOP_H;
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The byte becomes visible on the same edge that raises done.
        if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
            data_d = shreg_q;
        end else begin
            data_d = data_q;
        end

        done_d = (state_d == ST_DONE);
        busy_d = (state_d != ST_IDLE);

        // Pin levels follow the state being entered so they are registered.
        case (state_d)
            ST_IDLE: begin
                scl_d     = scl_q;
                sda_dir_d = 1'b0;
                sda_out_d = sda_out_q;
            end
            ST_RD_L, ST_RD_H: begin
                scl_d     = iic_is_high_phase(state_d);
                sda_dir_d = 1'b0;
                sda_out_d = sda_out_q;
            end
            ST_ACK_L, ST_ACK_H: begin
                scl_d     = iic_is_high_phase(state_d);
                sda_dir_d = 1'b1;
                sda_out_d = ack_lat_q ? IIC_ACK : IIC_NACK;
            end
`ifdef IIC_READ_STOP_EN
            ST_STOP_L, ST_STOP_H: begin
                scl_d     = iic_is_high_phase(state_d);
                sda_dir_d = 1'b1;
                sda_out_d = 1'b0;
            end
            ST_DONE: begin
                // SDA rising while SCL is high: the STOP condition.
                scl_d     = 1'b1;
                sda_dir_d = 1'b1;
                sda_out_d = 1'b1;
            end
`else
            ST_DONE: begin
                // Keep the bus owned: SCL low, SDA released.
                scl_d     = 1'b0;
                sda_dir_d = 1'b0;
                sda_out_d = sda_out_q;
            end
`endif
            default: begin
                scl_d     = 1'b1;
                sda_dir_d = 1'b0;
                sda_out_d = 1'b1;
            end
        endcase
    end

    // State and output registers; reset drops the partial byte immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ph_cnt_q  <= PH_ZERO;
            bit_cnt_q <= {IIC_BCNT_W{1'b0}};
            shreg_q   <= 8'h00;
            ack_lat_q <= 1'b0;
            data_q    <= 8'h00;
            scl_q     <= 1'b1;
            sda_dir_q <= 1'b0;
            sda_out_q <= 1'b1;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ph_cnt_q  <= ph_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            ack_lat_q <= ack_lat_d;
            data_q    <= data_d;
            scl_q     <= scl_d;
            sda_dir_q <= sda_dir_d;
            sda_out_q <= sda_out_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign sda     = sda_dir_q ? sda_out_q : 1'bz;
    assign scl     = scl_q;
    assign sda_dir = sda_dir_q;
    assign data    = data_q;
    assign done    = done_q;
    assign busy    = busy_q;

endmodule
